// File: rtl/rca_acc_if.sv
// Handshake/bus bundle between the upstream ripple-carry adder, rca_acc and its consumer.
interface rca_acc_if #(
   parameter int W     = 4,
   parameter int ACC_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     sumrca;
   logic             cout;
   logic             clr;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic             ovf;
   logic [2:0]       cnt;

   modport master (
      output in_valid, sumrca, cout, clr, out_ready,
      input  in_ready, out_valid, acc_out, ovf, cnt
   );

   modport slave (
      input  in_valid, sumrca, cout, clr, out_ready,
      output in_ready, out_valid, acc_out, ovf, cnt
   );
endinterface

// File: rtl/rca_acc.sv
// Frame accumulator for adder results {cout,sumrca}: sums N samples, then holds the total.
// Define RCA_ACC_SAT_EN to clamp on overflow instead of wrapping.
module rca_acc #(
   parameter int W     = 4,
   parameter int ACC_W = 8,
   parameter int N     = 4
) (
   input logic        clk,
   input logic        rst_n,
   rca_acc_if.slave   acc_if
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

   localparam logic [2:0] N_LAST = 3'(N);

   state_e           state_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] sample_ext;
   logic [ACC_W:0]   sum_wide;
   logic [2:0]       cnt_q;
   logic [2:0]       cnt_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             accept;

   assign sample_ext = ACC_W'({acc_if.cout, acc_if.sumrca});
   assign accept     = acc_if.in_valid & in_ready_q;

   // One extra bit on the sum exposes the carry out of the accumulator as the overflow event.
   // NOTE: every variable is assigned on every pass through always_comb, so no latch is inferred.
   always_comb begin
      sum_wide = {1'b0, acc_q} + {1'b0, sample_ext};
      cnt_d    = cnt_q + 3'd1;
      ovf_d    = ovf_q | sum_wide[ACC_W];
`ifdef RCA_ACC_SAT_EN
      acc_d    = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
`else
      acc_d    = sum_wide[ACC_W-1:0];
`endif
   end

   // NOTE: non-blocking assignments let every register see pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (acc_if.clr) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACC: begin
               if (accept) begin
                  // The first sample of a frame starts fresh; it cannot overflow since ACC_W > W.
                  acc_q <= (state_q == IDLE) ? sample_ext : acc_d;
                  ovf_q <= (state_q == IDLE) ? 1'b0 : ovf_d;
                  cnt_q <= cnt_d;
                  if (cnt_d == N_LAST) begin
                     state_q     <= DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q     <= ACC;
                  end
               end
            end
            DONE: begin
               if (acc_if.out_ready) begin
                  state_q     <= IDLE;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign acc_if.in_ready  = in_ready_q;
   assign acc_if.out_valid = out_valid_q;
   assign acc_if.acc_out   = acc_q;
   assign acc_if.ovf       = ovf_q;
   assign acc_if.cnt       = cnt_q;

endmodule

// File: tb/tb_rca_acc.sv
// Self-checking bench for rca_acc: two N=4 instances (ACC_W=8 and ACC_W=6) share stimulus,
// a third instance covers N=1. Expected values come from frame-level arithmetic.
module tb_rca_acc;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   rca_acc_if #(.W(4), .ACC_W(8)) if_a ();
   rca_acc_if #(.W(4), .ACC_W(6)) if_b ();
   rca_acc_if #(.W(4), .ACC_W(8)) if_c ();

   rca_acc #(.W(4), .ACC_W(8), .N(4)) dut_a (.clk(clk), .rst_n(rst_n), .acc_if(if_a.slave));
   rca_acc #(.W(4), .ACC_W(6), .N(4)) dut_b (.clk(clk), .rst_n(rst_n), .acc_if(if_b.slave));
   rca_acc #(.W(4), .ACC_W(8), .N(1)) dut_c (.clk(clk), .rst_n(rst_n), .acc_if(if_c.slave));

   int n_cmp = 0;
   int n_err = 0;

   // Frame-level reference: true running sum and sample count of the current frame.
   int total;
   int cnt_m;
   bit done_m;
   int acc_a_m, acc_b_m;
   bit ovf_a_m, ovf_b_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model_acc(input int t, input int w);
`ifdef RCA_ACC_SAT_EN
      return (t > (1 << w) - 1) ? (1 << w) - 1 : t;
`else
      return t % (1 << w);
`endif
   endfunction

   task automatic model_clear(input bit keep_ovf);
      total   = 0;
      cnt_m   = 0;
      done_m  = 1'b0;
      acc_a_m = 0;
      acc_b_m = 0;
      if (!keep_ovf) begin
         ovf_a_m = 1'b0;
         ovf_b_m = 1'b0;
      end
   endtask

   task automatic model_accept(input int s);
      total   = total + s;
      cnt_m   = cnt_m + 1;
      acc_a_m = model_acc(total, 8);
      acc_b_m = model_acc(total, 6);
      ovf_a_m = (total > 255);
      ovf_b_m = (total > 63);
      done_m  = (cnt_m == 4);
   endtask

   task automatic check_all(input string tag);
      check({tag, " acc_a"},  if_a.acc_out,   acc_a_m);
      check({tag, " cnt_a"},  if_a.cnt,       cnt_m);
      check({tag, " ovf_a"},  if_a.ovf,       ovf_a_m);
      check({tag, " oval_a"}, if_a.out_valid, done_m);
      check({tag, " irdy_a"}, if_a.in_ready,  !done_m);
      check({tag, " acc_b"},  if_b.acc_out,   acc_b_m);
      check({tag, " cnt_b"},  if_b.cnt,       cnt_m);
      check({tag, " ovf_b"},  if_b.ovf,       ovf_b_m);
      check({tag, " oval_b"}, if_b.out_valid, done_m);
      check({tag, " irdy_b"}, if_b.in_ready,  !done_m);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input int s, input bit c, input bit r);
      if_a.in_valid  = v;  if_b.in_valid  = v;
      if_a.sumrca    = s[3:0]; if_b.sumrca = s[3:0];
      if_a.cout      = s[4]; if_b.cout      = s[4];
      if_a.clr       = c;  if_b.clr       = c;
      if_a.out_ready = r;  if_b.out_ready = r;
   endtask

   task automatic push(input int s);
      drive(1'b1, s, 1'b0, 1'b0);
      tick();
      drive(1'b0, 0, 1'b0, 1'b0);
      model_accept(s);
   endtask

   task automatic release_frame(input bit v);
      drive(v, int'($urandom_range(0, 31)), 1'b0, 1'b1);
      tick();
      drive(1'b0, 0, 1'b0, 1'b0);
      model_clear(1'b1);
   endtask

   task automatic rand_frame();
      int clr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(0, 2)) begin
            drive(1'b0, int'($urandom_range(0, 31)), 1'b0, 1'b0);
            tick();
            check_all("gap");
         end
         if (k == clr_at) begin
            drive(1'b1, int'($urandom_range(0, 31)), 1'b1, 1'($urandom_range(0, 1)));
            tick();
            drive(1'b0, 0, 1'b0, 1'b0);
            model_clear(1'b0);
            check_all("rclr");
            return;
         end
         push(($urandom_range(0, 1) == 1) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 31)));
         check_all("racc");
      end
      repeat ($urandom_range(0, 3)) begin
         drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'b0, 1'b0);
         tick();
         check_all("rbp");
      end
      if ($urandom_range(0, 4) == 0) begin
         drive(1'b0, 0, 1'b1, 1'b0);
         tick();
         drive(1'b0, 0, 1'b0, 1'b0);
         model_clear(1'b0);
         check_all("rclrd");
      end else begin
         release_frame(1'($urandom_range(0, 1)));
         check_all("rrel");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 0, 1'b0, 1'b0);
      if_c.in_valid = 1'b0; if_c.sumrca = '0; if_c.cout = 1'b0;
      if_c.clr = 1'b0; if_c.out_ready = 1'b0;
      model_clear(1'b0);
      #12;
      check_all("reset");
      check("reset acc_c",  if_c.acc_out,  0);
      check("reset irdy_c", if_c.in_ready, 1);
      rst_n = 1'b1;
      tick();

      // Normal frame: 2+4+6+8.
      push(2);  check_all("nf1");
      push(4);  check_all("nf2");
      push(6);  check_all("nf3");
      push(8);  check_all("nf4");
      check("nf total", if_a.acc_out, 20);
      release_frame(1'b0);
      check_all("nfrel");

      // Overflow: four samples of 31 overflow the 6-bit accumulator.
      for (int i = 0; i < 4; i++) begin
         push(31);
         check_all("ovf");
      end
`ifdef RCA_ACC_SAT_EN
      check("ovf b total", if_b.acc_out, 63);
`else
      check("ovf b total", if_b.acc_out, 60);
`endif
      check("ovf b flag", if_b.ovf, 1);

      // Backpressure in DONE with in_valid held high; the held sample must not be absorbed.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, int'($urandom_range(0, 31)), 1'b0, 1'b0);
         tick();
         check_all("bp");
      end
      release_frame(1'b1);
      check_all("bprel");
      push(5);  check_all("newf");
      push(1);  push(1);  push(1);
      check_all("newf4");
      release_frame(1'b0);

      // Clear wins over the third accept; that sample is dropped.
      push(3);  push(4);
      drive(1'b1, 10, 1'b1, 1'b0);
      tick();
      drive(1'b0, 0, 1'b0, 1'b0);
      model_clear(1'b0);
      check_all("clrp");
      for (int i = 0; i < 4; i++) push(1);
      check_all("clrp_next");
      release_frame(1'b0);

      // Asynchronous reset mid-ACC with cnt=2, checked before any clock edge.
      push(7);  push(9);
      check_all("prerst");
      #2;
      rst_n = 1'b0;
      #1;
      model_clear(1'b0);
      check_all("arst");
      rst_n = 1'b1;
      #2;
      push(11);
      check_all("postrst");
      for (int i = 0; i < 3; i++) push(30);
      check_all("postrst4");
      release_frame(1'b0);
      check_all("postrst_rel");

      for (int f = 0; f < 40; f++) rand_frame();

      // N=1 instance: every accept completes a frame.
      if_c.in_valid = 1'b1; if_c.sumrca = 4'd9; if_c.cout = 1'b0;
      tick();
      check("n1 acc",  if_c.acc_out,   9);
      check("n1 cnt",  if_c.cnt,       1);
      check("n1 oval", if_c.out_valid, 1);
      check("n1 irdy", if_c.in_ready,  0);
      check("n1 ovf",  if_c.ovf,       0);
      if_c.sumrca = 4'd3;
      tick();
      check("n1 hold", if_c.acc_out, 9);
      if_c.in_valid = 1'b0; if_c.out_ready = 1'b1;
      tick();
      if_c.out_ready = 1'b0;
      check("n1 rel acc",  if_c.acc_out,   0);
      check("n1 rel oval", if_c.out_valid, 0);
      if_c.in_valid = 1'b1; if_c.sumrca = 4'd15; if_c.cout = 1'b1;
      tick();
      if_c.in_valid = 1'b0;
      check("n1 acc2", if_c.acc_out, 31);
      check("n1 cnt2", if_c.cnt,     1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
